alu_operand_stage: RTL
======================

// Module: alu_operand_stage
// PURPOSE
//  Decode-to-execute stage directly upstream of the RV32I ALU. Accepts one decoded-slot
//  instruction plus register-file read data per handshake, and forms the two 32-bit ALU
//  operands and the 4-bit ALU select. Buffers results in a 2-entry in-order skid queue,
//  so execute back-pressure never drops or reorders instructions.
// PARAMETERS
//  XLEN    32  datapath width; fixed for RV32I, other values unsupported
//  DEPTH   2   skid queue entries; fixed, count encodes EMPTY/ONE/TWO
// PORTS
//  clk            in   1   rising-edge clock
//  rst_n          in   1   asynchronous active-low reset
//  flush          in   1   synchronous squash of all queued and incoming entries
//  in_valid       in   1   upstream has an instruction
//  in_ready       out  1   stage can accept this cycle
//  in_instr       in   32  instruction word
//  in_pc          in   32  instruction address
//  in_rs1_data    in   32  rs1 read value, valid with in_valid
//  in_rs2_data    in   32  rs2 read value, valid with in_valid
//  out_valid      out  1   head entry valid toward ALU
//  out_ready      in   1   execute consumes head this cycle
//  out_op1        out  32  ALU first operand
//  out_op2        out  32  ALU second operand
//  out_alu_sel    out  4   0 ADD 1 SUB 2 SLL 3 SLT 4 SLTU 5 XOR 6 SRL 7 SRA 8 OR 9 AND
//  out_rd         out  5   destination register
//  out_rd_we      out  1   write-back enable; forced 0 when rd==0
//  out_is_store   out  1   op is STORE (op1+op2 is an address)
//  out_illegal    out  1   unsupported encoding
// BEHAVIOUR
//  - Reset: count=EMPTY; out_valid 0; all out_* data 0; in_ready 1 once rst_n high.
//  - Accept when in_valid&in_ready; pop when out_valid&out_ready. Push/pop same cycle legal.
//  - in_ready = (count!=TWO), from registered count only; no comb path from out_ready.
//  - Latency: accept at edge N -> out_valid at N+1 when EMPTY. FIFO order always.
//  - State: EMPTY->ONE on push; ONE->TWO push w/o pop; ONE->EMPTY pop w/o push.
//    ONE stays on push+pop; TWO->ONE on pop; TWO never pushes.
//  - flush (priority over all): count->EMPTY next edge; same-cycle in_valid discarded.
//  - Decode (sign-extended imms, immediates computed at accept):
//    OP 0110011: op1=rs1 op2=rs2; f3/f7 -> sel as table, f7=0100000 only on ADD->SUB,
//    SRL->SRA; shifts op2={27'b0,rs2[4:0]}; any other f7 illegal.
//    OP-IMM 0010011: op1=rs1 op2=I-imm; ADDI/SLTI/SLTIU/XORI/ORI/ANDI;
//    SLLI needs f7=0, SRLI f7=0 / SRAI f7=0100000, else illegal; op2={27'b0,shamt}.
//    LUI 0110111: op1=0 op2=U-imm sel ADD. AUIPC 0010111: op1=pc op2=U-imm sel ADD.
//    LOAD 0000011: rs1+I-imm ADD, rd_we. STORE 0100011: rs1+S-imm ADD, rd_we 0, is_store 1.
//    Other opcodes: illegal=1, op1=op2=0, sel ADD, rd_we 0, still queued for trap.
//  - rst_n low mid-operation: queue emptied at once, regardless of clk.
// TESTING
//  1 ADD x3,x1,x2 rs1=5 rs2=7 -> next cycle op1=5 op2=7 sel=0 rd=3 rd_we=1
//  2 SRAI x5,x6,4 rs1=0x80000000 -> op2=4 sel=7; f7=0100001 -> illegal=1 rd_we=0
//  3 AUIPC x1,0x12345 pc=0x100 -> op1=0x100 op2=0x12345000 sel=0; rd=0 variant -> rd_we=0
//  4 out_ready=0 while 3 pushed -> 2 held, in_ready=0 on 3rd; release -> order kept
//  5 count=TWO, flush with in_valid=1 -> next cycle out_valid=0, count EMPTY, nothing queued
//  6 rst_n low mid-stream -> out_valid 0 and outputs 0 immediately; in_ready 1 after release

Source files
------------

// File: rtl/alu_operand_stage_if.sv
// Handshake bundle between decode, the operand stage and the ALU.
// slave = operand stage view; master = upstream/downstream (driver) view.
interface alu_operand_stage_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [3:0]  out_alu_sel;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        out_is_store;
    logic        out_illegal;

    modport slave (
        input  flush, in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
        output in_ready, out_valid, out_op1, out_op2, out_alu_sel, out_rd,
               out_rd_we, out_is_store, out_illegal
    );

    modport master (
        output flush, in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
        input  in_ready, out_valid, out_op1, out_op2, out_alu_sel, out_rd,
               out_rd_we, out_is_store, out_illegal
    );
endinterface

// File: rtl/alu_operand_stage.sv
// RV32I operand/ALU-select former feeding a 2-entry in-order skid queue; 1-cycle latency.
// in_ready depends only on the registered count (no comb path from out_ready); flush squashes all.
module alu_operand_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_operand_stage_if.slave bus
);
    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [3:0]      sel;
        logic [4:0]      rd;
        logic            rd_we;
        logic            is_store;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {CNT_EMPTY = 2'd0, CNT_ONE = 2'd1, CNT_TWO = 2'd2} cnt_e;

    localparam logic [3:0] SEL_ADD = 4'd0, SEL_SUB = 4'd1, SEL_SLL = 4'd2, SEL_SLT = 4'd3,
                           SEL_SLTU = 4'd4, SEL_XOR = 4'd5, SEL_SRL = 4'd6, SEL_SRA = 4'd7,
                           SEL_OR = 4'd8, SEL_AND = 4'd9;

    cnt_e            r_cnt, w_cnt_nxt;
    entry_t          r_mem [DEPTH];
    logic            r_wr_ptr, r_rd_ptr;
    logic            w_push, w_pop, w_valid;
    entry_t          w_dec, w_head;
    logic [6:0]      w_opc, w_f7;
    logic [2:0]      w_f3;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_u;
    logic            w_legal, w_writes;

    assign w_opc   = bus.in_instr[6:0];
    assign w_rd    = bus.in_instr[11:7];
    assign w_f3    = bus.in_instr[14:12];
    assign w_f7    = bus.in_instr[31:25];
    assign w_imm_i = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
    assign w_imm_s = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
    assign w_imm_u = {bus.in_instr[31:12], 12'd0};

    always_comb begin
        w_dec    = '0;
        w_legal  = 1'b1;
        w_writes = 1'b1;
        w_dec.rd = w_rd;
        case (w_opc)
            7'b0110011: begin
                w_dec.op1 = bus.in_rs1_data;
                w_dec.op2 = bus.in_rs2_data;
                case (w_f3)
                    3'b000:  w_dec.sel = w_f7[5] ? SEL_SUB : SEL_ADD;
                    3'b001:  w_dec.sel = SEL_SLL;
                    3'b010:  w_dec.sel = SEL_SLT;
                    3'b011:  w_dec.sel = SEL_SLTU;
                    3'b100:  w_dec.sel = SEL_XOR;
                    3'b101:  w_dec.sel = w_f7[5] ? SEL_SRA : SEL_SRL;
                    3'b110:  w_dec.sel = SEL_OR;
                    default: w_dec.sel = SEL_AND;
                endcase
                if (w_f3 == 3'b001 || w_f3 == 3'b101)
                    w_dec.op2 = {27'd0, bus.in_rs2_data[4:0]};
                // funct7 0100000 only selects SUB/SRA; every other non-zero funct7 traps
                if (!(w_f7 == 7'd0 || (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))))
                    w_legal = 1'b0;
            end
            7'b0010011: begin
                w_dec.op1 = bus.in_rs1_data;
                w_dec.op2 = w_imm_i;
                case (w_f3)
                    3'b000:  w_dec.sel = SEL_ADD;
                    3'b001:  begin
                        w_dec.sel = SEL_SLL;
                        w_dec.op2 = {27'd0, bus.in_instr[24:20]};
                        w_legal   = (w_f7 == 7'd0);
                    end
                    3'b010:  w_dec.sel = SEL_SLT;
                    3'b011:  w_dec.sel = SEL_SLTU;
                    3'b100:  w_dec.sel = SEL_XOR;
                    3'b101:  begin
                        w_dec.sel = w_f7[5] ? SEL_SRA : SEL_SRL;
                        w_dec.op2 = {27'd0, bus.in_instr[24:20]};
                        w_legal   = (w_f7 == 7'd0) || (w_f7 == 7'b0100000);
                    end
                    3'b110:  w_dec.sel = SEL_OR;
                    default: w_dec.sel = SEL_AND;
                endcase
            end
            7'b0110111: w_dec.op2 = w_imm_u;
            7'b0010111: begin
                w_dec.op1 = bus.in_pc;
                w_dec.op2 = w_imm_u;
            end
            7'b0000011: begin
                w_dec.op1 = bus.in_rs1_data;
                w_dec.op2 = w_imm_i;
            end
            7'b0100011: begin
                w_dec.op1      = bus.in_rs1_data;
                w_dec.op2      = w_imm_s;
                w_dec.is_store = 1'b1;
                w_writes       = 1'b0;
            end
            default: w_legal = 1'b0;
        endcase
        // Illegal entries still travel down the pipe so execute can raise the trap
        if (!w_legal) begin
            w_dec.op1      = '0;
            w_dec.op2      = '0;
            w_dec.sel      = SEL_ADD;
            w_dec.is_store = 1'b0;
            w_writes       = 1'b0;
        end
        w_dec.illegal = !w_legal;
        w_dec.rd_we   = w_writes && (w_rd != 5'd0);
    end

    assign w_valid      = (r_cnt != CNT_EMPTY);
    assign bus.in_ready = (r_cnt != CNT_TWO);
    assign w_push       = bus.in_valid && bus.in_ready && !bus.flush;
    assign w_pop        = w_valid && bus.out_ready;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (bus.flush) begin
            w_cnt_nxt = CNT_EMPTY;
        end else begin
            case (r_cnt)
                CNT_EMPTY: if (w_push) w_cnt_nxt = CNT_ONE;
                CNT_ONE: begin
                    if (w_push && !w_pop)      w_cnt_nxt = CNT_TWO;
                    else if (w_pop && !w_push) w_cnt_nxt = CNT_EMPTY;
                end
                CNT_TWO:   if (w_pop) w_cnt_nxt = CNT_ONE;
                default:   w_cnt_nxt = CNT_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= CNT_EMPTY;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (bus.flush) begin
                r_wr_ptr <= 1'b0;
                r_rd_ptr <= 1'b0;
            end else begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= w_dec;
                    r_wr_ptr        <= !r_wr_ptr;
                end
                if (w_pop) r_rd_ptr <= !r_rd_ptr;
            end
        end
    end

    // Stale slots are masked so the ALU side sees zeros whenever nothing is valid
    assign w_head           = w_valid ? r_mem[r_rd_ptr] : '0;
    assign bus.out_valid    = w_valid;
    assign bus.out_op1      = w_head.op1;
    assign bus.out_op2      = w_head.op2;
    assign bus.out_alu_sel  = w_head.sel;
    assign bus.out_rd       = w_head.rd;
    assign bus.out_rd_we    = w_head.rd_we;
    assign bus.out_is_store = w_head.is_store;
    assign bus.out_illegal  = w_head.illegal;
endmodule
